// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the RV32E load/store unit:
//   - lsu_state_t : FSM state encoding (IDLE, BUS, RESP)
//   - LOAD/STORE funct3 constants, also used by the control unit
//   - funct3_legal(): whether a funct3 is a valid LOAD or STORE width
// Optional feature macro used by the unit: LSU_ALIGN_CHECK_EN
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // LOAD funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // STORE funct3
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else
            return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                   (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane logic for the load/store unit.
//   Store side : byte strobes and lane-replicated write data.
//   Load side  : lane extraction with sign/zero extension.
//   err        : illegal funct3, or (with LSU_ALIGN_CHECK_EN) misalignment.
// Ports:
//   we          in  1  : 1 = store, 0 = load
//   funct3      in  3  : access width / signedness
//   addr_lo     in  2  : byte offset within the word
//   store_data  in  32 : rs2 value
//   load_word   in  32 : word read from memory
//   wstrb       out 4  : byte-lane enables for the store
//   store_lanes out 32 : replicated store data
//   load_data   out 32 : extracted and extended load value
//   err         out 1  : access cannot be performed
// Macro: LSU_ALIGN_CHECK_EN enables misalignment errors.
// -----------------------------------------------------------------------------
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        misaligned;

    // Lane selects equivalent to shifting right by 8*addr[1:0] / 16*addr[1]
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = load_word[7:0];
            2'd1:    byte_sel = load_word[15:8];
            2'd2:    byte_sel = load_word[23:16];
            default: byte_sel = load_word[31:24];
        endcase
        half_sel = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    end

    always_comb begin
        wstrb       = 4'b0000;
        store_lanes = 32'd0;
        load_data   = 32'd0;
        case (funct3[1:0])
            2'b00: begin
                wstrb       = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_data   = funct3[2] ? {24'd0, byte_sel}
                                        : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                // addr[0] is ignored for lane choice; only addr[1] picks the half
                wstrb       = 4'b0011 << {addr_lo[1], 1'b0};
                store_lanes = {2{store_data[15:0]}};
                load_data   = funct3[2] ? {16'd0, half_sel}
                                        : {{16{half_sel[15]}}, half_sel};
            end
            2'b10: begin
                wstrb       = 4'b1111;
                store_lanes = store_data;
                load_data   = load_word;
            end
            default: begin
                wstrb       = 4'b0000;
                store_lanes = 32'd0;
                load_data   = 32'd0;
            end
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign err = !funct3_legal(we, funct3) || misaligned;

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// RV32E load/store unit: accepts one LOAD/STORE at a time, performs a single
// valid/ready transaction on the data-memory bus, and returns extended data.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake from execute
//   req_we, req_funct3         : store flag and access width
//   req_addr, req_wdata        : effective address, rs2 value
//   resp_valid/resp_rdata/err  : one-cycle completion pulse and result
//   mem_valid/mem_ready        : data-memory bus handshake
//   mem_we/addr/wstrb/wdata    : bus write controls (word-aligned address)
//   mem_rdata                  : read word, valid with mem_ready
// Macro: LSU_ALIGN_CHECK_EN (misaligned half/word accesses raise resp_err).
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    lsu_state_t            state_reg, state_next;
    logic                  we_reg, we_next;
    logic [2:0]            funct3_reg, funct3_next;
    logic [1:0]            addr_lo_reg, addr_lo_next;
    logic                  mem_valid_reg, mem_valid_next;
    logic                  mem_we_reg, mem_we_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [3:0]            mem_wstrb_reg, mem_wstrb_next;
    logic [31:0]           mem_wdata_reg, mem_wdata_next;
    logic                  resp_valid_reg, resp_valid_next;
    logic                  resp_err_reg, resp_err_next;
    logic [31:0]           resp_rdata_reg, resp_rdata_next;

    // The single lane unit sees the live request while idle and the latched
    // request afterwards, so it serves both store setup and load extraction.
    logic                  al_we;
    logic [2:0]            al_funct3;
    logic [1:0]            al_addr_lo;
    logic [3:0]            al_wstrb;
    logic [31:0]           al_store_lanes;
    logic [31:0]           al_load_data;
    logic                  al_err;

    assign al_we      = (state_reg == IDLE) ? req_we        : we_reg;
    assign al_funct3  = (state_reg == IDLE) ? req_funct3    : funct3_reg;
    assign al_addr_lo = (state_reg == IDLE) ? req_addr[1:0] : addr_lo_reg;

    lsu_align u_align (
        .we          (al_we),
        .funct3      (al_funct3),
        .addr_lo     (al_addr_lo),
        .store_data  (req_wdata),
        .load_word   (mem_rdata),
        .wstrb       (al_wstrb),
        .store_lanes (al_store_lanes),
        .load_data   (al_load_data),
        .err         (al_err)
    );

    assign req_ready = (state_reg == IDLE) && !rst;

    always_comb begin
        state_next      = state_reg;
        we_next         = we_reg;
        funct3_next     = funct3_reg;
        addr_lo_next    = addr_lo_reg;
        mem_valid_next  = mem_valid_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wstrb_next  = mem_wstrb_reg;
        mem_wdata_next  = mem_wdata_reg;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rdata_next = resp_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    we_next      = req_we;
                    funct3_next  = req_funct3;
                    addr_lo_next = req_addr[1:0];
                    if (al_err) begin
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                        resp_rdata_next = 32'd0;
                    end else begin
                        state_next     = BUS;
                        mem_valid_next = 1'b1;
                        mem_we_next    = req_we;
                        mem_addr_next  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wstrb_next = req_we ? al_wstrb : 4'b0000;
                        mem_wdata_next = req_we ? al_store_lanes : 32'd0;
                    end
                end
            end
            BUS: begin
                // mem_* hold their registered values until the bus accepts
                if (mem_ready) begin
                    state_next      = RESP;
                    mem_valid_next  = 1'b0;
                    mem_we_next     = 1'b0;
                    mem_wstrb_next  = 4'b0000;
                    resp_valid_next = 1'b1;
                    resp_rdata_next = we_reg ? 32'd0 : al_load_data;
                end
            end
            RESP: begin
                state_next      = IDLE;
                resp_rdata_next = 32'd0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            funct3_reg     <= 3'd0;
            addr_lo_reg    <= 2'd0;
            mem_valid_reg  <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wstrb_reg  <= 4'd0;
            mem_wdata_reg  <= 32'd0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'd0;
        end else begin
            state_reg      <= state_next;
            we_reg         <= we_next;
            funct3_reg     <= funct3_next;
            addr_lo_reg    <= addr_lo_next;
            mem_valid_reg  <= mem_valid_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wstrb_reg  <= mem_wstrb_next;
            mem_wdata_reg  <= mem_wdata_next;
            resp_valid_reg <= resp_valid_next;
            resp_err_reg   <= resp_err_next;
            resp_rdata_reg <= resp_rdata_next;
        end
    end

    assign mem_valid  = mem_valid_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wstrb  = mem_wstrb_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit for the RV32E core. It accepts one decoded LOAD or STORE operation at a time from the execute stage: access width from funct3, effective address, and store data. It performs a single valid/ready transaction on the data-memory bus, then returns lane-extracted, sign- or zero-extended load data. It sits between the ALU address output and the register-file write-back mux.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: execute stage presents an operation.
- `req_ready`  out  1: unit can accept; `(state==IDLE) && !rst`.
- `req_we`  in  1: 1 = STORE, 0 = LOAD.
- `req_funct3`  in  3: LB/LH/LW/LBU/LHU or SB/SH/SW encoding.
- `req_addr`  in  ADDR_WIDTH: effective byte address.
- `req_wdata`  in  32: rs2 value; low bits are used for SB/SH.
- `resp_valid`  out  1: one-cycle pulse; operation complete.
- `resp_rdata`  out  32: extended load data; 0 for stores and errors.
- `resp_err`  out  1: qualified by `resp_valid`; illegal funct3 or misaligned.
- `mem_valid`  out  1: bus request.
- `mem_ready`  in  1: bus accepts; `mem_rdata` is valid in the same cycle.
- `mem_we`  out  1: write enable.
- `mem_addr`  out  ADDR_WIDTH: word-aligned, `{req_addr[ADDR_WIDTH-1:2], 2'b00}`.
- `mem_wstrb`  out  4: byte-lane enables; 0 for reads.
- `mem_wdata`  out  32: lane-replicated store data.
- `mem_rdata`  in  32: read word.

## Operation
- FSM states:
  - IDLE: on `req_valid && req_ready`, latch the request.
    - Legal and aligned → BUS.
    - Otherwise → RESP with `resp_err=1`, no bus transaction.
  - BUS: `mem_valid=1`. All `mem_*` outputs are held stable until `mem_ready`. On `mem_ready`, capture `mem_rdata` and go to RESP.
  - RESP: `resp_valid=1` for exactly one cycle, then → IDLE.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: 011–111.
- Store lanes:
  - SB: `wstrb = 4'b0001 << addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - SH: `wstrb = 4'b0011 << (2*addr[1])`, `wdata = {2{wdata[15:0]}}`.
  - SW: `wstrb = 4'b1111`, `wdata = wdata`.
- Load extraction: shift `rdata` right by `8*addr[1:0]` for byte accesses, or by `16*addr[1]` for halfword accesses. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `mem_ready` while `mem_valid=0` is ignored.
- `req_valid` outside IDLE is ignored; the execute stage stalls on `req_ready`.

## Timing
- Reset values:
  - State IDLE.
  - `mem_valid`, `mem_we`, `resp_valid`, `resp_err` all 0.
  - `mem_addr`, `mem_wdata`, `resp_rdata` all 0; `mem_wstrb` 0.
  - `req_ready` is 0 while `rst=1`, and 1 the cycle after release.
- All outputs except `req_ready` are registered.
- Latency:
  - Accept at cycle N; `mem_valid` at N+1.
  - If `mem_ready` arrives at cycle M (M ≥ N+1), `resp_valid` is asserted at M+1. The minimum request-to-response latency is 2 cycles.
  - Error path: `resp_valid` at N+1.
- Throughput: the next request is accepted the cycle after RESP. Peak rate is one operation per 3 cycles.
- Reset during BUS: `mem_valid` drops the next cycle and the transaction is abandoned. The memory must tolerate withdrawal on reset only.
- Reset during RESP: the pulse is suppressed if reset lands before its edge.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - LH/LHU/SH with `addr[0]=1` → `resp_err=1`, no bus access.
  - LW/SW with `addr[1:0]!=0` → `resp_err=1`, no bus access.
- `LSU_ALIGN_CHECK_EN` undefined:
  - No misalignment error. Halfwords use lane `addr[1]` (`addr[0]` ignored); words ignore `addr[1:0]`.
  - `resp_err` reports illegal funct3 only.

## Structure
- The shared core package holds:
  - `lsu_state_t` enum (IDLE, BUS, RESP).
  - The LOAD/STORE funct3 constants used by the control unit.
- Sub-module `lsu_align` (combinational) provides store lane steering/strobes and load extraction/extension. It is instantiated once; the FSM lives in `load_store_unit`.

## Test plan
- SB at addr 0x103, `wdata=0xAABBCCDD`, `mem_ready` at first cycle → `mem_addr=0x100`, `wstrb=4'b1000`, `wdata=0xDDDDDDDD`. `resp_valid` 2 cycles after accept, `rdata=0`.
- LB at 0x201, `mem_rdata=0x1234_80FF` → `resp_rdata=0xFFFFFF80`. LBU at the same address → `0x00000080`.
- LH at 0x302, `mem_rdata=0x8001_0000`, `mem_ready` delayed 3 cycles → `mem_*` stable throughout, `resp_rdata=0xFFFF8001`, one-cycle `resp_valid`.
- LW at 0x402 with `LSU_ALIGN_CHECK_EN` → no `mem_valid`, `resp_err=1` at N+1. Without the macro → `mem_addr=0x400`, `resp_err=0`.
- Load with funct3=3'b011 → `resp_err=1`, no bus access, `req_ready` high again after RESP.
- `rst` asserted during BUS with `mem_ready` low → `mem_valid=0` next cycle, no `resp_valid`, and a new request is accepted after reset release.
